imm_decode_stage: RTL

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage_pkg.sv | 68 ++++++
 rtl/imm_decode_stage_field_extract.sv | 89 ++++++++
 rtl/imm_decode_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_pkg.sv
// Shared constants for the immediate decode stage: opcodes, funct3 codes,
// format codes, buffer occupancy states and instruction field bit ranges.
package imm_decode_stage_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 codes of the shift-immediate instructions under OP-IMM
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Format code reported with each decoded entry
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_t;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  // Instruction field bit ranges
  localparam int OPC_MSB     = 6;
  localparam int OPC_LSB     = 0;
  localparam int F3_MSB      = 14;
  localparam int F3_LSB      = 12;
  localparam int SIGN_BIT    = 31;
  localparam int I_MSB       = 31;
  localparam int I_LSB       = 20;
  localparam int S_HI_MSB    = 31;
  localparam int S_HI_LSB    = 25;
  localparam int S_LO_MSB    = 11;
  localparam int S_LO_LSB    = 7;
  localparam int B_B11_BIT   = 7;
  localparam int B_MID_MSB   = 30;
  localparam int B_MID_LSB   = 25;
  localparam int B_LO_MSB    = 11;
  localparam int B_LO_LSB    = 8;
  localparam int U_MSB       = 31;
  localparam int U_LSB       = 12;
  localparam int J_HI_MSB    = 19;
  localparam int J_HI_LSB    = 12;
  localparam int J_B11_BIT   = 20;
  localparam int J_LO_MSB    = 30;
  localparam int J_LO_LSB    = 21;
  localparam int SHAMT_LSB   = 20;
  localparam int SHAMT32_MSB = 24;
  localparam int SHAMT64_MSB = 25;
  localparam int SHAMT32_W   = SHAMT32_MSB - SHAMT_LSB + 1;
  localparam int SHAMT64_W   = SHAMT64_MSB - SHAMT_LSB + 1;

endpackage

// File: rtl/imm_decode_stage_field_extract.sv
// Combinational immediate extraction: classifies the opcode, builds the
// sign-extended immediate and flags unrecognised opcodes.
module imm_field_extract
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_U = 1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic        use_shamt;
  fmt_t        fmt_v;

  assign opcode = inst[OPC_MSB:OPC_LSB];
  assign funct3 = inst[F3_MSB:F3_LSB];

  // Opcode classification and 32-bit sign-extended immediate assembly
  always_comb begin
    imm32     = '0;
    use_shamt = 1'b0;
    fmt_v     = FMT_NONE;
    illegal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        fmt_v   = FMT_R;
        illegal = 1'b0;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt_v   = FMT_I;
        illegal = 1'b0;
        imm32   = {{20{inst[SIGN_BIT]}}, inst[I_MSB:I_LSB]};
        // Shifts carry an unsigned shift amount instead of a signed value
        if (opcode == OPC_OP_IMM && (funct3 == F3_SLL || funct3 == F3_SRX)) begin
          use_shamt = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt_v   = FMT_S;
        illegal = 1'b0;
        imm32   = {{20{inst[SIGN_BIT]}}, inst[S_HI_MSB:S_HI_LSB], inst[S_LO_MSB:S_LO_LSB]};
      end
      OPC_BRANCH: begin
        fmt_v   = FMT_B;
        illegal = 1'b0;
        imm32   = {{20{inst[SIGN_BIT]}}, inst[B_B11_BIT], inst[B_MID_MSB:B_MID_LSB],
                   inst[B_LO_MSB:B_LO_LSB], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        // Without U support these opcodes fall through as unrecognised
        if (HAS_U != 0) begin
          fmt_v   = FMT_U;
          illegal = 1'b0;
          imm32   = {inst[U_MSB:U_LSB], 12'b0};
        end
      end
      OPC_JAL: begin
        fmt_v   = FMT_J;
        illegal = 1'b0;
        imm32   = {{12{inst[SIGN_BIT]}}, inst[J_HI_MSB:J_HI_LSB], inst[J_B11_BIT],
                   inst[J_LO_MSB:J_LO_LSB], 1'b0};
      end
      default: begin
        fmt_v   = FMT_NONE;
        illegal = 1'b1;
      end
    endcase
  end

  assign fmt = fmt_v;

  // Width adaptation: shift amount width and sign extension follow XLEN
  generate
    if (XLEN == 64) begin : g_x64
      assign imm = use_shamt ? {{(XLEN-SHAMT64_W){1'b0}}, inst[SHAMT64_MSB:SHAMT_LSB]}
                             : {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_x32
      assign imm = use_shamt ? {{(XLEN-SHAMT32_W){1'b0}}, inst[SHAMT32_MSB:SHAMT_LSB]}
                             : imm32;
    end
  endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes at the input, then buffers decoded
// entries in a two-entry skid buffer (main, skid) with registered in_ready.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_U = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  occ_state_t      state_reg;
  logic            in_ready_reg;

  logic [XLEN-1:0] main_imm_reg;
  logic [2:0]      main_fmt_reg;
  logic            main_illegal_reg;
  logic [31:0]     main_inst_reg;
  logic [XLEN-1:0] main_pc_reg;

  logic [XLEN-1:0] skid_imm_reg;
  logic [2:0]      skid_fmt_reg;
  logic            skid_illegal_reg;
  logic [31:0]     skid_inst_reg;
  logic [XLEN-1:0] skid_pc_reg;

  logic            push;
  logic            pop;

  imm_field_extract #(
    .XLEN  (XLEN),
    .HAS_U (HAS_U)
  ) u_extract (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign push = in_valid && in_ready_reg;
  assign pop  = (state_reg != ST_EMPTY) && out_ready;

  // Occupancy FSM and buffer moves; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_EMPTY;
      in_ready_reg     <= 1'b1;
      main_imm_reg     <= '0;
      main_fmt_reg     <= FMT_NONE;
      main_illegal_reg <= 1'b0;
      main_inst_reg    <= '0;
      main_pc_reg      <= '0;
      skid_imm_reg     <= '0;
      skid_fmt_reg     <= FMT_NONE;
      skid_illegal_reg <= 1'b0;
      skid_inst_reg    <= '0;
      skid_pc_reg      <= '0;
    end else if (flush) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (push) begin
            main_imm_reg     <= dec_imm;
            main_fmt_reg     <= dec_fmt;
            main_illegal_reg <= dec_illegal;
            main_inst_reg    <= in_inst;
            main_pc_reg      <= in_pc;
            state_reg        <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            // Main drains while the new entry replaces it
            main_imm_reg     <= dec_imm;
            main_fmt_reg     <= dec_fmt;
            main_illegal_reg <= dec_illegal;
            main_inst_reg    <= in_inst;
            main_pc_reg      <= in_pc;
          end else if (push) begin
            skid_imm_reg     <= dec_imm;
            skid_fmt_reg     <= dec_fmt;
            skid_illegal_reg <= dec_illegal;
            skid_inst_reg    <= in_inst;
            skid_pc_reg      <= in_pc;
            state_reg        <= ST_FULL;
            in_ready_reg     <= 1'b0;
          end else if (pop) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_imm_reg     <= skid_imm_reg;
            main_fmt_reg     <= skid_fmt_reg;
            main_illegal_reg <= skid_illegal_reg;
            main_inst_reg    <= skid_inst_reg;
            main_pc_reg      <= skid_pc_reg;
            state_reg        <= ST_ONE;
            in_ready_reg     <= 1'b1;
          end
        end
        default: begin
          state_reg    <= ST_EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = (state_reg != ST_EMPTY);
  assign out_imm     = main_imm_reg;
  assign out_fmt     = main_fmt_reg;
  assign out_illegal = main_illegal_reg;
  assign out_inst    = main_inst_reg;
  assign out_pc      = main_pc_reg;

endmodule
